// File: rtl/hdmi_packet_pkg.sv
// Shared packet-type encodings and audio sample types for the HDMI data-island scheduler.
package hdmi_packet_pkg;

  typedef enum logic [7:0] {
    PKT_NULL         = 8'd0,
    PKT_ACR          = 8'd1,
    PKT_AUDIO_SAMPLE = 8'd2
  } pkt_type_t;

  // Widest L-PCM sample the hdmi core accepts; per-instance pairs use AUDIO_BIT_WIDTH.
  localparam int unsigned AUDIO_MAX_WIDTH = 24;
  typedef logic [1:0][AUDIO_MAX_WIDTH-1:0] audio_pair_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock FIFO with first-word fall-through head and an explicit occupancy counter.
module audio_sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Picks the data-island packet for each hdmi slot: ACR first, then buffered audio, else Null.
module hdmi_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned AUDIO_BIT_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned ACR_PERIOD      = 25200
) (
  input  logic                           clk_pixel,
  input  logic                           reset_n,
  input  logic                           audio_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0]     audio_in [1:0],
  input  logic                           packet_enable,
  output logic [7:0]                     packet_type,
  output logic [AUDIO_BIT_WIDTH-1:0]     audio_sample_word [1:0],
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow
);

  localparam int unsigned CW = $clog2(ACR_PERIOD);
  localparam logic [CW-1:0] ACR_LAST = CW'(ACR_PERIOD - 1);
  localparam int unsigned PAIR_W = 2 * AUDIO_BIT_WIDTH;

  logic [CW-1:0]     acr_cnt;
  logic              acr_pending;
  logic              acr_wrap;
  pkt_type_t         sel;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              consume_acr;
  logic [PAIR_W-1:0] fifo_din;
  logic [PAIR_W-1:0] fifo_head;

  assign fifo_din = {audio_in[1], audio_in[0]};

  audio_sample_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_pixel),
    .reset_n (reset_n),
    .push    (audio_valid),
    .pop     (pop),
    .din     (fifo_din),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    sel = PKT_NULL;
    if (acr_pending)      sel = PKT_ACR;
    else if (!fifo_empty) sel = PKT_AUDIO_SAMPLE;
  end

  assign packet_type = sel;
  assign acr_wrap    = (acr_cnt == ACR_LAST);
  assign consume_acr = packet_enable && (sel == PKT_ACR);
  assign pop         = packet_enable && (sel == PKT_AUDIO_SAMPLE);

  always_comb begin
    audio_sample_word[0] = '0;
    audio_sample_word[1] = '0;
    if (!fifo_empty) begin
      audio_sample_word[0] = fifo_head[AUDIO_BIT_WIDTH-1:0];
      audio_sample_word[1] = fifo_head[PAIR_W-1:AUDIO_BIT_WIDTH];
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      acr_cnt     <= '0;
      acr_pending <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      acr_cnt <= acr_wrap ? '0 : acr_cnt + CW'(1);
      // A fresh request outranks a consume landing on the same edge.
      if (acr_wrap)         acr_pending <= 1'b1;
      else if (consume_acr) acr_pending <= 1'b0;
      if (audio_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed cycle-by-cycle vectors for hdmi_packet_scheduler with ACR_PERIOD=8, FIFO_DEPTH=4.
module tb_hdmi_packet_scheduler;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic        audio_valid;
  logic [15:0] audio_in [1:0];
  logic        packet_enable;
  logic [7:0]  packet_type;
  logic [15:0] audio_sample_word [1:0];
  logic [2:0]  fifo_level;
  logic        overflow;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_packet_scheduler #(
    .AUDIO_BIT_WIDTH (16),
    .FIFO_DEPTH      (4),
    .ACR_PERIOD      (8)
  ) dut (
    .clk_pixel         (clk_pixel),
    .reset_n           (reset_n),
    .audio_valid       (audio_valid),
    .audio_in          (audio_in),
    .packet_enable     (packet_enable),
    .packet_type       (packet_type),
    .audio_sample_word (audio_sample_word),
    .fifo_level        (fifo_level),
    .overflow          (overflow)
  );

  // Each row: inputs driven during a cycle, and outputs expected in that same cycle.
  typedef struct {
    logic        rst_n;
    logic        v;
    logic [15:0] l;
    logic [15:0] r;
    logic        en;
    logic [7:0]  t;
    logic [2:0]  lvl;
    logic        ovf;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;

  vec_t vecs [$];

  function automatic void add(input logic rst_n, input logic v, input logic [15:0] l,
                              input logic [15:0] r, input logic en, input logic [7:0] t,
                              input logic [2:0] lvl, input logic ovf,
                              input logic [15:0] w0, input logic [15:0] w1);
    vec_t e;
    e.rst_n = rst_n; e.v = v; e.l = l; e.r = r; e.en = en;
    e.t = t; e.lvl = lvl; e.ovf = ovf; e.w0 = w0; e.w1 = w1;
    vecs.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] t, input logic [2:0] lvl,
                               input logic ovf, input logic [15:0] w0, input logic [15:0] w1);
    check({tag, " type"},  32'(packet_type),          32'(t));
    check({tag, " level"}, 32'(fifo_level),           32'(lvl));
    check({tag, " ovf"},   32'(overflow),             32'(ovf));
    check({tag, " wordL"}, 32'(audio_sample_word[0]), 32'(w0));
    check({tag, " wordR"}, 32'(audio_sample_word[1]), 32'(w1));
  endtask

  initial begin
    //  rst v  L        R        en  type lvl ovf wordL    wordR
    // reset release, ACR then Null consume
    add(1, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000); // C0
    add(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000); // C1
    // single pair push then pop
    add(1, 1, 16'h1234, 16'hABCD, 0, 0, 0, 0, 16'h0000, 16'h0000); // C2
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 1, 0, 16'h1234, 16'hABCD); // C3
    add(1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000); // C4
    // ACR wrap pre-empts queued audio
    add(1, 1, 16'h1111, 16'h2222, 0, 0, 0, 0, 16'h0000, 16'h0000); // C5
    add(1, 1, 16'h3333, 16'h4444, 0, 2, 1, 0, 16'h1111, 16'h2222); // C6
    add(1, 0, 16'h0000, 16'h0000, 0, 2, 2, 0, 16'h1111, 16'h2222); // C7 wrap
    add(1, 0, 16'h0000, 16'h0000, 1, 1, 2, 0, 16'h1111, 16'h2222); // C8
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 2, 0, 16'h1111, 16'h2222); // C9
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 1, 0, 16'h3333, 16'h4444); // C10
    // push into empty on a Null consume: slot stays Null
    add(1, 1, 16'h5555, 16'h6666, 1, 0, 0, 0, 16'h0000, 16'h0000); // C11
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 1, 0, 16'h5555, 16'h6666); // C12
    // overflow: five pushes, no pops
    add(1, 1, 16'h0101, 16'h1010, 0, 0, 0, 0, 16'h0000, 16'h0000); // C13
    add(1, 1, 16'h0202, 16'h2020, 0, 2, 1, 0, 16'h0101, 16'h1010); // C14
    add(1, 1, 16'h0303, 16'h3030, 0, 2, 2, 0, 16'h0101, 16'h1010); // C15 wrap
    add(1, 1, 16'h0404, 16'h4040, 0, 1, 3, 0, 16'h0101, 16'h1010); // C16
    add(1, 1, 16'h0505, 16'h5050, 0, 1, 4, 0, 16'h0101, 16'h1010); // C17
    for (int i = 18; i <= 22; i++)
      add(1, 0, 16'h0000, 16'h0000, 0, 1, 4, 1, 16'h0101, 16'h1010); // C18..C22
    // ACR consume on the wrap edge: pending survives
    add(1, 0, 16'h0000, 16'h0000, 1, 1, 4, 1, 16'h0101, 16'h1010); // C23 wrap
    add(1, 0, 16'h0000, 16'h0000, 1, 1, 4, 1, 16'h0101, 16'h1010); // C24
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 4, 1, 16'h0101, 16'h1010); // C25
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 3, 1, 16'h0202, 16'h2020); // C26
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 2, 1, 16'h0303, 16'h3030); // C27
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 1, 1, 16'h0404, 16'h4040); // C28
    // refill to three, then reset mid-operation
    add(1, 1, 16'h0A0A, 16'hA0A0, 0, 0, 0, 1, 16'h0000, 16'h0000); // C29
    add(1, 1, 16'h0B0B, 16'hB0B0, 0, 2, 1, 1, 16'h0A0A, 16'hA0A0); // C30
    add(1, 1, 16'h0C0C, 16'hC0C0, 0, 2, 2, 1, 16'h0A0A, 16'hA0A0); // C31 wrap
    add(0, 0, 16'h0000, 16'h0000, 0, 1, 3, 1, 16'h0A0A, 16'hA0A0); // C32 reset
    // fill after reset, then push+pop while full
    add(1, 1, 16'hA1A1, 16'h1A1A, 1, 1, 0, 0, 16'h0000, 16'h0000); // R0
    add(1, 1, 16'hA2A2, 16'h2A2A, 0, 2, 1, 0, 16'hA1A1, 16'h1A1A); // R1
    add(1, 1, 16'hA3A3, 16'h3A3A, 0, 2, 2, 0, 16'hA1A1, 16'h1A1A); // R2
    add(1, 1, 16'hA4A4, 16'h4A4A, 0, 2, 3, 0, 16'hA1A1, 16'h1A1A); // R3
    add(1, 1, 16'hA5A5, 16'h5A5A, 1, 2, 4, 0, 16'hA1A1, 16'h1A1A); // R4
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 4, 0, 16'hA2A2, 16'h2A2A); // R5
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 3, 0, 16'hA3A3, 16'h3A3A); // R6
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 2, 0, 16'hA4A4, 16'h4A4A); // R7 wrap
    add(1, 0, 16'h0000, 16'h0000, 1, 1, 1, 0, 16'hA5A5, 16'h5A5A); // R8
    add(1, 0, 16'h0000, 16'h0000, 1, 2, 1, 0, 16'hA5A5, 16'h5A5A); // R9
    add(1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000); // R10

    reset_n       = 1'b0;
    audio_valid   = 1'b0;
    audio_in[0]   = '0;
    audio_in[1]   = '0;
    packet_enable = 1'b0;
    repeat (2) @(posedge clk_pixel);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_pixel);
      reset_n       = vecs[i].rst_n;
      audio_valid   = vecs[i].v;
      audio_in[0]   = vecs[i].l;
      audio_in[1]   = vecs[i].r;
      packet_enable = vecs[i].en;
      check_outputs($sformatf("row%0d", i), vecs[i].t, vecs[i].lvl, vecs[i].ovf,
                    vecs[i].w0, vecs[i].w1);
    end

    // audio_valid during reset is ignored
    @(negedge clk_pixel);
    reset_n     = 1'b0;
    audio_valid = 1'b1;
    audio_in[0] = 16'h7777;
    audio_in[1] = 16'h8888;
    @(negedge clk_pixel);
    reset_n       = 1'b1;
    audio_valid   = 1'b0;
    check_outputs("rst_push", 8'd1, 3'd0, 1'b0, 16'h0000, 16'h0000);
    // ACR consume and push on the same edge: audio is next
    audio_valid   = 1'b1;
    audio_in[0]   = 16'h9999;
    audio_in[1]   = 16'h6666;
    packet_enable = 1'b1;
    @(negedge clk_pixel);
    audio_valid   = 1'b0;
    packet_enable = 1'b0;
    check_outputs("acr_push", 8'd2, 3'd1, 1'b0, 16'h9999, 16'h6666);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
